// File: rtl/sipo_rx_pkg.sv
// Shared types and constants for the serial frame receiver.
package sipo_rx_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = $clog2(DATA_W_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

endpackage

// File: rtl/sipo_shift_reg.sv
// Left-shifting data register for the receiver, with even parity of its contents.
module sipo_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              din,
  output logic [DATA_W-1:0] data,
  output logic              par
);

  logic [DATA_W-1:0] data_r;

  function automatic logic even_par(input logic [DATA_W-1:0] v);
    return ^v;
  endfunction

  // shift register: new bit enters at the LSB, first bit ends at the MSB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r <= {DATA_W{1'b0}};
    end else if (shift_en) begin
      data_r <= {data_r[DATA_W-2:0], din};
    end else begin
      data_r <= data_r;
    end
  end

  assign data = data_r;
  assign par  = even_par(data_r);

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start/data/parity/stop deframing into a one-deep
// valid/ready output register with parity, framing and overrun status.
module sipo_frame_rx
  import sipo_rx_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              si,
  input  logic              bit_en,
  output logic [DATA_W-1:0] po,
  output logic              po_valid,
  input  logic              po_ready,
  output logic              po_perr,
  output logic              frame_err,
  output logic              overrun,
  input  logic              clr_ovr
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  rx_state_e         state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              perr_r, perr_s;
  logic              shift_en_s;
  logic              complete_s;
  logic              ferr_s;
  logic [DATA_W-1:0] shift_data_s;
  logic              shift_par_s;

  logic [DATA_W-1:0] po_r;
  logic              po_valid_r;
  logic              po_perr_r;
  logic              frame_err_r;
  logic              overrun_r;
  logic              load_s;
  logic              drop_s;

  sipo_shift_reg #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en_s),
    .din      (si),
    .data     (shift_data_s),
    .par      (shift_par_s)
  );

  // receive FSM state, bit counter and captured parity result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      perr_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      perr_r  <= perr_s;
    end
  end

  // next-state decode; everything holds while the bit strobe is low
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    perr_s     = perr_r;
    shift_en_s = 1'b0;
    complete_s = 1'b0;
    ferr_s     = 1'b0;
    if (bit_en) begin
      case (state_r)
        IDLE: begin
          if (!si) begin
            state_s = DATA;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            state_s = IDLE;
          end
        end
        DATA: begin
          shift_en_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            cnt_s   = cnt_r + CNT_W'(1);
            state_s = DATA;
          end
        end
        PARITY: begin
          perr_s  = (PARITY_EN != 0) ? (shift_par_s ^ si) : 1'b0;
          state_s = STOP;
        end
        STOP: begin
          if (si) begin
            complete_s = 1'b1;
          end else begin
            ferr_s = 1'b1;
          end
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // a finished byte either lands in the output register or is dropped
  always_comb begin
    load_s = 1'b0;
    drop_s = 1'b0;
    if (complete_s) begin
      if (!po_valid_r || po_ready) begin
        load_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // output register with valid/ready handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      po_r       <= {DATA_W{1'b0}};
      po_valid_r <= 1'b0;
      po_perr_r  <= 1'b0;
    end else if (load_s) begin
      po_r       <= shift_data_s;
      po_valid_r <= 1'b1;
      po_perr_r  <= (PARITY_EN != 0) ? perr_r : 1'b0;
    end else if (po_valid_r && po_ready) begin
      po_valid_r <= 1'b0;
    end else begin
      po_valid_r <= po_valid_r;
    end
  end

  // frame error pulse and sticky overrun; a new drop beats a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= ferr_s;
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (clr_ovr) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign po        = po_r;
  assign po_valid  = po_valid_r;
  assign po_perr   = po_perr_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Randomised bench for sipo_frame_rx: frame-level reference model compared every cycle.
module tb_sipo_frame_rx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          si = 1'b1;
  logic          bit_en = 1'b0;
  logic          po_ready = 1'b0;
  logic          clr_ovr = 1'b0;
  logic [DW-1:0] po;
  logic          po_valid, po_perr, frame_err, overrun;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sipo_frame_rx #(.DATA_W(DW), .PARITY_EN(1)) dut (
    .clk(clk), .rst(rst), .si(si), .bit_en(bit_en),
    .po(po), .po_valid(po_valid), .po_ready(po_ready), .po_perr(po_perr),
    .frame_err(frame_err), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  // stimulus context: the frame being sent and the stop-bit event the model consumes
  logic [DW-1:0] cur_data = '0;
  logic          cur_pbit = 1'b0;
  logic          stop_evt = 1'b0;
  logic [DW-1:0] ev_data = '0;
  logic          ev_perr = 1'b0;
  logic          ev_sbit = 1'b1;
  int strobe_mode = 0;   // 0 every cycle, 1 one-in-three, 2 random
  int ready_mode  = 1;   // 0 never, 1 always, 2 random, 3 only on stop-bit edges
  int clr_prob    = 0;   // 0 never, n: about one cycle in n
  int strobe_ph   = 0;

  // reference model: what the output register holds, by frame-level rules
  logic [DW-1:0] m_po = '0;
  logic m_valid = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_po <= '0; m_valid <= 1'b0; m_perr <= 1'b0; m_ferr <= 1'b0; m_ovr <= 1'b0;
    end else begin
      m_ferr <= stop_evt && !ev_sbit;
      if (stop_evt && ev_sbit && (!m_valid || po_ready)) begin
        m_po <= ev_data; m_perr <= ev_perr; m_valid <= 1'b1;
      end else if (m_valid && po_ready) begin
        m_valid <= 1'b0;
      end
      if (stop_evt && ev_sbit && m_valid && !po_ready) m_ovr <= 1'b1;
      else if (clr_ovr) m_ovr <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // every-cycle comparison of the DUT against the model
  always @(posedge clk) begin
    #1;
    check("po", 32'(po), 32'(m_po));
    check("po_valid", 32'(po_valid), 32'(m_valid));
    check("po_perr", 32'(po_perr), 32'(m_perr));
    check("frame_err", 32'(frame_err), 32'(m_ferr));
    check("overrun", 32'(overrun), 32'(m_ovr));
  end

  task automatic drive_cycle(input logic b, input logic is_stop, input logic force_en);
    @(negedge clk);
    si = b;
    case (strobe_mode)
      0: bit_en = 1'b1;
      1: begin bit_en = (strobe_ph == 2); strobe_ph = (strobe_ph + 1) % 3; end
      default: bit_en = ($urandom_range(0, 1) == 1);
    endcase
    if (force_en) bit_en = 1'b1;
    case (ready_mode)
      0: po_ready = 1'b0;
      1: po_ready = 1'b1;
      2: po_ready = ($urandom_range(0, 1) == 1);
      default: po_ready = is_stop && bit_en;
    endcase
    clr_ovr = (clr_prob > 0) && ($urandom_range(0, clr_prob - 1) == 0);
    if (is_stop) begin
      ev_data = cur_data;
      ev_perr = (^cur_data) ^ cur_pbit;
      ev_sbit = b;
    end
    stop_evt = is_stop && bit_en;
  endtask

  task automatic send_bit(input logic b, input logic is_stop);
    int n = 0;
    do begin
      drive_cycle(b, is_stop, n >= 40);
      n++;
    end while (!bit_en);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; stop_evt = 1'b0;
    bit_en = ($urandom_range(0, 1) == 1); si = ($urandom_range(0, 1) == 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; stop_evt = 1'b0; si = 1'b1; bit_en = 1'b0;
  endtask

  // abort_after = k > 0 resets the DUT after k data bits
  task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic sbit,
                            input int abort_after);
    cur_data = d;
    cur_pbit = pbit;
    send_bit(1'b0, 1'b0);
    for (int i = DW - 1; i >= 0; i--) begin
      send_bit(d[i], 1'b0);
      if (abort_after == DW - i) begin
        do_reset();
        return;
      end
    end
    send_bit(pbit, 1'b0);
    send_bit(sbit, 1'b1);
  endtask

  task automatic at_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    at_edge();
    check("rst_po", 32'(po), 32'h0);
    check("rst_valid", 32'(po_valid), 32'h0);
    check("rst_perr", 32'(po_perr), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // clean 0xC6 frame
    strobe_mode = 0; ready_mode = 1; clr_prob = 0;
    send_bit(1'b1, 1'b0);
    send_frame(8'hC6, 1'b0, 1'b1, 0);
    at_edge();
    check("t1_po", 32'(po), 32'hC6);
    check("t1_model_po", 32'(m_po), 32'hC6);
    check("t1_valid", 32'(po_valid), 32'h1);
    check("t1_perr", 32'(po_perr), 32'h0);
    send_bit(1'b1, 1'b0);
    at_edge();
    check("t1_valid_drop", 32'(po_valid), 32'h0);

    // wrong parity bit still delivers the byte
    send_frame(8'hC6, 1'b1, 1'b1, 0);
    at_edge();
    check("t2_po", 32'(po), 32'hC6);
    check("t2_perr", 32'(po_perr), 32'h1);
    check("t2_model_perr", 32'(m_perr), 32'h1);

    // bad stop bit
    send_frame(8'h3F, 1'b0, 1'b0, 0);
    at_edge();
    check("t3_ferr", 32'(frame_err), 32'h1);
    check("t3_valid", 32'(po_valid), 32'h0);
    send_bit(1'b1, 1'b0);
    at_edge();
    check("t3_ferr_pulse", 32'(frame_err), 32'h0);

    // overrun with a stalled consumer, then clear and drain
    ready_mode = 0;
    send_frame(8'hC6, 1'b0, 1'b1, 0);
    send_frame(8'h3F, 1'b0, 1'b1, 0);
    at_edge();
    check("t4_po_held", 32'(po), 32'hC6);
    check("t4_ovr", 32'(overrun), 32'h1);
    check("t4_model_ovr", 32'(m_ovr), 32'h1);
    clr_prob = 1;
    send_bit(1'b1, 1'b0);
    at_edge();
    check("t4_ovr_clr", 32'(overrun), 32'h0);
    check("t4_valid_kept", 32'(po_valid), 32'h1);
    clr_prob = 0; ready_mode = 1;
    send_bit(1'b1, 1'b0);
    at_edge();
    check("t4_drain", 32'(po_valid), 32'h0);

    // replace on the same edge as the handshake
    ready_mode = 3;
    send_frame(8'hC6, 1'b0, 1'b1, 0);
    send_frame(8'h3F, 1'b0, 1'b1, 0);
    at_edge();
    check("t5_po", 32'(po), 32'h3F);
    check("t5_valid", 32'(po_valid), 32'h1);
    check("t5_ovr", 32'(overrun), 32'h0);
    ready_mode = 1;
    send_bit(1'b1, 1'b0);

    // reset mid-frame, with steady and 1-in-3 strobes
    for (int s = 0; s < 2; s++) begin
      strobe_mode = s;
      send_frame(8'hC6, 1'b0, 1'b1, 4);
      send_frame(8'h3F, 1'b0, 1'b1, 0);
      at_edge();
      check("t6_po", 32'(po), 32'h3F);
      check("t6_valid", 32'(po_valid), 32'h1);
      send_bit(1'b1, 1'b0);
    end

    // randomised traffic
    clr_prob = 8;
    for (int f = 0; f < 300; f++) begin
      logic [DW-1:0] d;
      int gap;
      d = DW'($urandom);
      strobe_mode = $urandom_range(0, 2);
      ready_mode = $urandom_range(0, 3);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) send_bit(1'b1, 1'b0);
      send_frame(d, (^d) ^ ($urandom_range(0, 4) == 0),
                 $urandom_range(0, 7) != 0,
                 ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, DW)) : 0);
    end
    ready_mode = 1; clr_prob = 0; strobe_mode = 0;
    repeat (4) send_bit(1'b1, 1'b0);
    at_edge();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sipo_frame_rx.md
# sipo_frame_rx

Serial-to-parallel frame receiver sitting directly downstream of the 8-bit PISO serialiser. It samples the serial line on a bit strobe, strips start/parity/stop framing, and reassembles the data byte. It then presents the byte on a one-deep valid/ready output register with parity, framing and overrun status. Line format: idle high, start bit 0, DATA_W data bits MSB first, optional even parity bit, stop bit 1.

## Interface
- DATA_W, 8, data bits per frame (≥2)
- PARITY_EN, 1, 1 = even parity bit present between data and stop; 0 = no parity bit, po_perr tied 0
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, asynchronous assert, active-low (0 = reset)
- si  input  1  serial line
- bit_en  input  1  bit strobe; si is sampled only on clk edges where bit_en=1
- po  output  DATA_W  received byte, MSB = first data bit received
- po_valid  output  1  po holds an unconsumed byte
- po_ready  input  1  consumer accepts po when po_valid & po_ready at a clk edge
- po_perr  output  1  parity mismatch for byte in po (qualified by po_valid)
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- overrun  output  1  sticky: a completed byte was dropped because output register was full
- clr_ovr  input  1  synchronous clear of overrun

## Operation
- States: IDLE, DATA, PARITY, STOP. State changes only on edges with bit_en=1.
- IDLE: si=0 → DATA, bit counter = 0; si=1 → stay.
- DATA: shift si into shift register LSB, previous contents shift left, running XOR parity updated; counter increments; after DATA_W-th bit → PARITY (PARITY_EN=1) or STOP.
- PARITY: perr_int = (XOR of data bits) ^ si; → STOP.
- STOP: si=1 → frame complete; si=0 → frame_err pulse, byte discarded; both → IDLE.
- Frame complete with po_valid=0, or with po_valid=1 & po_ready=1 same edge: po ← shift register, po_perr ← perr_int, po_valid=1.
- Frame complete with po_valid=1 & po_ready=0: new byte dropped, po unchanged, overrun ← 1.
- Handshake without completion: po_valid & po_ready → po_valid=0 next cycle; po/po_perr keep last value.
- overrun: clr_ovr=1 clears; if clr_ovr and new overrun on same edge, overrun=1 (set wins).
- Parity-errored bytes are delivered, not dropped.
- A continuous-0 line after a frame error re-enters DATA immediately (0 in IDLE is a start bit); no break detection.
- bit_en=0 freezes receive FSM, counter, shift register; handshake and clr_ovr still act.

## Timing
- Reset (rst=0), all asynchronous: state=IDLE, counter=0, shift register=0, po=0, po_valid=0, po_perr=0, frame_err=0, overrun=0. Partial frame discarded; first frame after reset needs a fresh start bit.
- Latency: po_valid rises on the clk edge that samples the stop bit (registered; visible from that edge).
- Minimum frame = 1 + DATA_W + PARITY_EN + 1 strobes (11 for defaults); back-to-back frames legal with no idle bit.
- frame_err high for exactly one clk after the stop-bit edge.
- po_valid never drops without a po_ready handshake; po stable while po_valid=1.

## Structure
- Package sipo_rx_pkg: state enum (IDLE, DATA, PARITY, STOP), default DATA_W constant, counter width $clog2(DATA_W).
- Sub-module sipo_shift_reg: DATA_W-bit left shift register with shift enable and running parity output; the FSM and output register stay in sipo_frame_rx.
- All outputs registered.

## Test plan
- Defaults, bit_en=1 every cycle, po_ready=1; send 0,1,1,0,0,0,1,1,0,0,1 (0xC6, parity 0, stop 1) → po=0xC6, po_valid one cycle, po_perr=0, frame_err=0.
- Send 0xC6 with parity bit 1 → po=0xC6, po_valid=1, po_perr=1.
- Send 0x3F with stop bit 0 → frame_err one-cycle pulse, po_valid stays 0, FSM back to IDLE.
- po_ready=0; send 0xC6 then 0x3F back-to-back → po=0xC6 held, overrun=1 after second stop; clr_ovr → overrun=0; po_ready=1 → po_valid drops.
- po_valid=1 (0xC6) and po_ready asserted on the stop-bit edge of 0x3F → po=0x3F, po_valid stays 1, overrun=0.
- Assert rst=0 mid-frame after 4 data bits of 0xC6, release, send 0x3F → po=0x3F only; bit_en toggling 1-in-3 gives the same result.
